// File: rtl/regfile.sv
// ---------------------------------------------------------------------------
// regfile -- architectural register file for the pipelined ARM32 core.
//
// Sixteen architectural registers R0..R15 plus an 11-bit program counter.
// R0 always reads as zero and R15 reads as the zero-extended PC. Neither
// can be written through the data write ports. Storage therefore exists
// only for R1..R14.
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   w_data1/w_addr1/w_en1           ALU result write port 1 (lowest priority)
//   w_data2/w_addr2/w_en2           ALU result write port 2
//   w_data_ldr/w_addr_ldr/w_en_ldr  load writeback port (highest priority)
//   A_addr, B_addr, shift_addr,
//   str_addr, reg_addr              combinational read addresses
//   A_data, B_data, shift_data,
//   str_data, reg_output            read data for the matching address
//   sel_pc, load_pc                 PC next-value select and update enable
//   start_pc, dp_pc                 PC start vector and branch target
//   pc_out                          registered program counter
//
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write
// data to the read ports. When it is undefined, reads return stored values.
// ---------------------------------------------------------------------------
module regfile #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] w_data1,
    input  logic [3:0]        w_addr1,
    input  logic              w_en1,
    input  logic [DATA_W-1:0] w_data2,
    input  logic [3:0]        w_addr2,
    input  logic              w_en2,
    input  logic [DATA_W-1:0] w_data_ldr,
    input  logic [3:0]        w_addr_ldr,
    input  logic              w_en_ldr,
    input  logic [3:0]        A_addr,
    input  logic [3:0]        B_addr,
    input  logic [3:0]        shift_addr,
    input  logic [3:0]        str_addr,
    input  logic [3:0]        reg_addr,
    input  logic [1:0]        sel_pc,
    input  logic              load_pc,
    input  logic [PC_W-1:0]   start_pc,
    input  logic [PC_W-1:0]   dp_pc,
    output logic [DATA_W-1:0] A_data,
    output logic [DATA_W-1:0] B_data,
    output logic [DATA_W-1:0] shift_data,
    output logic [DATA_W-1:0] str_data,
    output logic [DATA_W-1:0] reg_output,
    output logic [PC_W-1:0]   pc_out
);

    // Backing storage exists only for the writable registers R1..R14.
    logic [DATA_W-1:0] regs [1:14];
    logic [PC_W-1:0]   pc;

    // Per-register next value: the highest-priority enabled port aimed at
    // the register wins (ldr > port 2 > port 1). Otherwise the register
    // keeps its stored value. Address 0 and address 15 never match, because
    // only indices 1..14 are examined.
    logic [DATA_W-1:0] next_val [1:14];
    logic              hit      [1:14];

    always_comb begin
        for (int i = 1; i <= 14; i++) begin
            next_val[i] = regs[i];
            hit[i]      = 1'b0;
            if (w_en_ldr && w_addr_ldr == 4'(i)) begin
                next_val[i] = w_data_ldr;
                hit[i]      = 1'b1;
            end else if (w_en2 && w_addr2 == 4'(i)) begin
                next_val[i] = w_data2;
                hit[i]      = 1'b1;
            end else if (w_en1 && w_addr1 == 4'(i)) begin
                next_val[i] = w_data1;
                hit[i]      = 1'b1;
            end
        end
    end

    // Register array update. Reset clears every register and takes
    // precedence over any write in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i <= 14; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 1; i <= 14; i++) begin
                if (hit[i]) begin
                    regs[i] <= next_val[i];
                end
            end
        end
    end

    // Program counter update. The increment wraps naturally at PC_W bits.
    // sel_pc == 3 is an explicit hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= '0;
        end else if (load_pc) begin
            case (sel_pc)
                2'd0:    pc <= start_pc;
                2'd1:    pc <= pc + 1'b1;
                2'd2:    pc <= dp_pc;
                default: pc <= pc;
            endcase
        end
    end

    assign pc_out = pc;

    // Build a 16-entry read view shared by all five read ports. R0 is zero
    // and R15 is the zero-extended PC. With bypass compiled in, the middle
    // entries show the value about to be written, so a read sees a
    // same-cycle write.
    logic [DATA_W-1:0] view [0:15];

    always_comb begin
        view[0]  = '0;
        view[15] = DATA_W'(pc);
        for (int i = 1; i <= 14; i++) begin
`ifdef REGFILE_BYPASS_EN
            view[i] = next_val[i];
`else
            view[i] = regs[i];
`endif
        end
    end

    assign A_data     = view[A_addr];
    assign B_data     = view[B_addr];
    assign shift_data = view[shift_addr];
    assign str_data   = view[str_addr];
    assign reg_output = view[reg_addr];

endmodule

// File: tb/tb_regfile.sv
// ---------------------------------------------------------------------------
// tb_regfile -- self-checking bench for regfile.
// A plain array model tracks R0..R15 and the PC. Writes are applied in
// port 1, port 2, ldr order, so the last write naturally wins.
// ---------------------------------------------------------------------------
module tb_regfile;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] w_data1 = '0, w_data2 = '0, w_data_ldr = '0;
    logic [3:0]  w_addr1 = '0, w_addr2 = '0, w_addr_ldr = '0;
    logic        w_en1 = 1'b0, w_en2 = 1'b0, w_en_ldr = 1'b0;
    logic [3:0]  A_addr = '0, B_addr = '0, shift_addr = '0, str_addr = '0, reg_addr = '0;
    logic [1:0]  sel_pc = '0;
    logic        load_pc = 1'b0;
    logic [10:0] start_pc = '0, dp_pc = '0;
    logic [31:0] A_data, B_data, shift_data, str_data, reg_output;
    logic [10:0] pc_out;

    int checks = 0;
    int errors = 0;

    logic [31:0] model [16];
    int          modelPc;

    regfile dut (
        .clk(clk), .rst(rst),
        .w_data1(w_data1), .w_addr1(w_addr1), .w_en1(w_en1),
        .w_data2(w_data2), .w_addr2(w_addr2), .w_en2(w_en2),
        .w_data_ldr(w_data_ldr), .w_addr_ldr(w_addr_ldr), .w_en_ldr(w_en_ldr),
        .A_addr(A_addr), .B_addr(B_addr), .shift_addr(shift_addr),
        .str_addr(str_addr), .reg_addr(reg_addr),
        .sel_pc(sel_pc), .load_pc(load_pc), .start_pc(start_pc), .dp_pc(dp_pc),
        .A_data(A_data), .B_data(B_data), .shift_data(shift_data),
        .str_data(str_data), .reg_output(reg_output), .pc_out(pc_out)
    );

    always #5 clk = ~clk;

    // Count one comparison and report it if the observed value differs.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Architectural view of a read: zero, the PC, or the stored value.
    function automatic logic [31:0] expRead(input logic [3:0] a);
        if (a == 4'd0)  return 32'h0;
        if (a == 4'd15) return 32'(modelPc);
        return model[a];
    endfunction

    // Apply one write to the model. Addresses 0 and 15 are not writable.
    task automatic modelWrite(input logic en, input logic [3:0] a, input logic [31:0] d);
        if (en && a != 4'd0 && a != 4'd15) model[a] = d;
    endtask

    // Update the model with whatever the DUT samples at this edge.
    task automatic modelEdge();
        if (rst) begin
            for (int i = 0; i < 16; i++) model[i] = '0;
            modelPc = 0;
        end else begin
            modelWrite(w_en1, w_addr1, w_data1);
            modelWrite(w_en2, w_addr2, w_data2);
            modelWrite(w_en_ldr, w_addr_ldr, w_data_ldr);
            if (load_pc) begin
                case (sel_pc)
                    2'd0: modelPc = int'(start_pc);
                    2'd1: modelPc = (modelPc + 1) % 2048;
                    2'd2: modelPc = int'(dp_pc);
                    default: ;
                endcase
            end
        end
    endtask

    // Clock one edge with the currently driven inputs, then release all
    // enables and reset so that later reads are stable.
    task automatic applyStimulus();
        @(posedge clk);
        modelEdge();
        #1;
        w_en1 = 1'b0; w_en2 = 1'b0; w_en_ldr = 1'b0;
        load_pc = 1'b0; rst = 1'b0;
    endtask

    task automatic checkPorts(input string tag);
        #1;
        checkOutput({tag, "_A"},     A_data,     expRead(A_addr));
        checkOutput({tag, "_B"},     B_data,     expRead(B_addr));
        checkOutput({tag, "_shift"}, shift_data, expRead(shift_addr));
        checkOutput({tag, "_str"},   str_data,   expRead(str_addr));
        checkOutput({tag, "_reg"},   reg_output, expRead(reg_addr));
        checkOutput({tag, "_pc"},    32'(pc_out), 32'(modelPc));
    endtask

    task automatic sweepRegs(input string tag);
        for (int a = 0; a < 16; a++) begin
            reg_addr = 4'(a);
            #1;
            checkOutput($sformatf("%s_r%0d", tag, a), reg_output, expRead(4'(a)));
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) model[i] = 'x;
        modelPc = 0;

        // Reset state
        rst = 1'b1;
        applyStimulus();
        applyStimulus();
        sweepRegs("reset");
        checkOutput("reset_pc", 32'(pc_out), 32'h0);

        // Write to R0 is discarded
        w_en1 = 1'b1; w_addr1 = 4'd0; w_data1 = 32'hDEADBEEF;
        applyStimulus();
        A_addr = 4'd0;
        #1 checkOutput("r0_zero", A_data, 32'h0);

        // Fill R1..R7 and R9..R15; the R15 write must be dropped
        for (int i = 1; i <= 7; i++) begin
            w_en1 = 1'b1; w_addr1 = 4'(i);     w_data1 = 32'(i);
            w_en2 = 1'b1; w_addr2 = 4'(i + 8); w_data2 = 32'(i + 8);
            applyStimulus();
            A_addr = 4'(i); reg_addr = 4'd15;
            #1;
            checkOutput($sformatf("fill_A%0d", i), A_data, 32'(i));
            checkOutput($sformatf("fill_r15_%0d", i), reg_output, expRead(4'd15));
        end

        // Parallel reads on independent ports
        for (int i = 1; i <= 5; i++) begin
            A_addr = 4'(i); B_addr = 4'(i + 1); shift_addr = 4'(i + 2); str_addr = 4'd9;
            #1;
            checkOutput($sformatf("rd_A%0d", i), A_data, 32'(i));
            checkOutput($sformatf("rd_B%0d", i), B_data, 32'(i + 1));
            checkOutput($sformatf("rd_S%0d", i), shift_data, 32'(i + 2));
            checkOutput($sformatf("rd_str%0d", i), str_data, 32'd9);
        end

        // Three-way collision on R10: ldr wins
        w_en1 = 1'b1; w_addr1 = 4'd10; w_data1 = 32'd1;
        w_en2 = 1'b1; w_addr2 = 4'd10; w_data2 = 32'd2;
        w_en_ldr = 1'b1; w_addr_ldr = 4'd10; w_data_ldr = 32'h12345678;
        applyStimulus();
        reg_addr = 4'd10;
        #1 checkOutput("collide_ldr", reg_output, 32'h12345678);

        // Port 2 beats port 1
        w_en1 = 1'b1; w_addr1 = 4'd3; w_data1 = 32'hAAAA0001;
        w_en2 = 1'b1; w_addr2 = 4'd3; w_data2 = 32'hBBBB0002;
        applyStimulus();
        reg_addr = 4'd3;
        #1 checkOutput("collide_p2", reg_output, 32'hBBBB0002);

        // PC sequencing
        load_pc = 1'b1; sel_pc = 2'd0; start_pc = 11'd100;
        applyStimulus(); #1 checkOutput("pc_start", 32'(pc_out), 32'd100);
        load_pc = 1'b1; sel_pc = 2'd1;
        applyStimulus(); #1 checkOutput("pc_inc", 32'(pc_out), 32'd101);
        load_pc = 1'b1; sel_pc = 2'd2; dp_pc = 11'd7;
        applyStimulus(); #1 checkOutput("pc_dp", 32'(pc_out), 32'd7);
        load_pc = 1'b0; sel_pc = 2'd1;
        applyStimulus(); #1 checkOutput("pc_noload", 32'(pc_out), 32'd7);
        load_pc = 1'b1; sel_pc = 2'd3;
        applyStimulus(); #1 checkOutput("pc_hold3", 32'(pc_out), 32'd7);
        load_pc = 1'b1; sel_pc = 2'd2; dp_pc = 11'd2047;
        applyStimulus();
        load_pc = 1'b1; sel_pc = 2'd1;
        applyStimulus(); #1 checkOutput("pc_wrap", 32'(pc_out), 32'd0);
        reg_addr = 4'd15; dp_pc = 11'd1234; load_pc = 1'b1; sel_pc = 2'd2;
        applyStimulus(); #1 checkOutput("r15_pc", reg_output, 32'd1234);

        // Randomized traffic against the model
        for (int n = 0; n < 300; n++) begin
            w_en1 = 1'($urandom); w_addr1 = 4'($urandom); w_data1 = $urandom;
            w_en2 = 1'($urandom); w_addr2 = 4'($urandom); w_data2 = $urandom;
            w_en_ldr = 1'($urandom); w_addr_ldr = 4'($urandom); w_data_ldr = $urandom;
            if ($urandom_range(0, 3) == 0) begin
                w_addr2 = w_addr1; w_addr_ldr = w_addr1;
            end
            load_pc = 1'($urandom); sel_pc = 2'($urandom);
            start_pc = 11'($urandom); dp_pc = 11'($urandom);
            applyStimulus();
            A_addr = 4'($urandom); B_addr = 4'($urandom); shift_addr = 4'($urandom);
            str_addr = 4'($urandom); reg_addr = 4'($urandom);
            checkPorts($sformatf("rand%0d", n));
        end

        // Reset mid-run overrides writes and PC load
        w_en1 = 1'b1; w_addr1 = 4'd5; w_data1 = 32'h55;
        w_en2 = 1'b1; w_addr2 = 4'd6; w_data2 = 32'h66;
        w_en_ldr = 1'b1; w_addr_ldr = 4'd7; w_data_ldr = 32'h77;
        load_pc = 1'b1; sel_pc = 2'd0; start_pc = 11'd500;
        rst = 1'b1;
        applyStimulus();
        sweepRegs("midrst");
        checkOutput("midrst_pc", 32'(pc_out), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile.md
Name: regfile

Overview:
- Architectural register file for the pipelined ARM32 core: sixteen 32-bit registers R0–R15 plus a separate 11-bit program counter.
- Three write ports: ALU result port 1, ALU result port 2, and the load (LDR) writeback port.
- Five combinational read ports: operands A, B, shift amount, store data, and a debug/observation read.
- Sits between decode (read addresses) and writeback (write ports); also owns PC update for the fetch stage.

Parameters:
- DATA_W, 32, register width in bits
- PC_W, 11, program counter width (instruction-memory word address)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous active-high reset
- w_data1  in  32  write data, port 1
- w_addr1  in  4  write address, port 1
- w_en1  in  1  write enable, port 1
- w_data2  in  32  write data, port 2
- w_addr2  in  4  write address, port 2
- w_en2  in  1  write enable, port 2
- w_data_ldr  in  32  load writeback data
- w_addr_ldr  in  4  load writeback address
- w_en_ldr  in  1  load writeback enable
- A_addr, B_addr, shift_addr, str_addr, reg_addr  in  4 each  read addresses
- sel_pc  in  2  PC next-value select
- load_pc  in  1  PC update enable
- start_pc  in  11  PC start/reset-vector value
- dp_pc  in  11  branch/datapath-computed PC
- A_data, B_data, shift_data, str_data, reg_output  out  32 each  read data for the matching address
- pc_out  out  11  current PC

Behaviour:
- Reset: when rst=1 at a rising clk edge, all registers and the PC are cleared to 0. Reset overrides all writes and load_pc.
- R0 is hardwired zero:
  - Any read of address 0 returns 32'h0.
  - Writes to address 0 are discarded on every port.
- R15 is not writable through the data ports; writes to address 15 are discarded.
- A read of address 15 returns {21'b0, pc_out}.
- Writes:
  - On a rising clk edge, each enabled port writes its data to its address.
  - If two or more enabled ports target the same address in one cycle, priority is ldr > port 2 > port 1. Only the highest-priority data is stored.
- Reads:
  - Purely combinational from the stored array.
  - A write becomes visible on read ports only after the clock edge that performs it (no same-cycle forwarding unless the optional feature is compiled in).
  - All five read ports are independent and may alias the same or different registers.
- PC update, on a rising clk edge when load_pc=1:
  - sel_pc=0: PC <= start_pc
  - sel_pc=1: PC <= PC+1, wrapping from 2047 to 0
  - sel_pc=2: PC <= dp_pc
  - sel_pc=3: PC holds
- When load_pc=0, the PC holds.
- pc_out is the registered PC value.
- Unknown or X enables are not required to be tolerated. Latency: writes take 1 cycle; reads take 0.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- When defined: each read port forwards same-cycle write data when an enabled write port targets the read address (address not 0 or 15). The same ldr > port 2 > port 1 priority applies.
- When undefined: no forwarding; reads return the pre-edge stored value.

Test Plan:
1. Write 32'hDEADBEEF to R0 via port 1, clock; A_addr=0 -> A_data=0.
2. Loop i=1..7, clocking once per iteration:
   - port 1 writes value i to Ri; port 2 writes i+8 to R(i+8).
   - A_addr=i -> A_data=i after each edge.
   - R15 stays PC-derived, never 15.
3. Disable writes; for i=1..5, set A/B/shift addresses to i, i+1, i+2 -> data equal to the addresses.
   - With str_addr=R9 -> str_data=9.
4. Port 1, port 2 and ldr all write R10 with 1, 2 and 32'h12345678 in one cycle -> reg_output (reg_addr=10) = 32'h12345678.
5. PC sequencing:
   - load_pc=1, sel_pc=0, start_pc=100 -> pc_out=100.
   - sel_pc=1 -> 101.
   - sel_pc=2, dp_pc=7 -> 7.
   - load_pc=0 -> holds 7.
   - PC=2047 with sel_pc=1 -> 0.
6. rst=1 mid-run with writes enabled -> all reads 0, pc_out=0 after the edge.
